// File: rtl/adc_bitslip_align_if.sv
// ----------------------------------------------------------------------------
// adc_bitslip_align_if
// Bundle between the per-channel ISERDES2 deserialisers / channel logic and the
// bitslip word-alignment controller.
//   start  : one-cycle pulse, (re)start alignment of all channels
//   din    : deserialised words, channel k = din[k*WIDTH +: WIDTH]
//   dout   : din delayed one clock, same packing
//   bs     : per-channel bitslip pulse toward ISERDES2 BITSLIP
//   locked : per-channel aligned flag
//   fail   : per-channel "no slip position matched" flag
//   slips  : per-channel slip count, channel k = slips[k*CNTW +: CNTW]
//   busy   : at least one channel is still aligning
// master = driver/consumer side, slave = the alignment controller.
// ----------------------------------------------------------------------------
interface adc_bitslip_align_if #(
  parameter int NCH   = 4,
  parameter int WIDTH = 6,
  parameter int CNTW  = 4
);
  logic                  start;
  logic [NCH*WIDTH-1:0]  din;
  logic [NCH*WIDTH-1:0]  dout;
  logic [NCH-1:0]        bs;
  logic [NCH-1:0]        locked;
  logic [NCH-1:0]        fail;
  logic [NCH*CNTW-1:0]   slips;
  logic                  busy;

  modport master (
    output start, din,
    input  dout, bs, locked, fail, slips, busy
  );

  modport slave (
    input  start, din,
    output dout, bs, locked, fail, slips, busy
  );
endinterface

// File: rtl/adc_bitslip_align.sv
// ----------------------------------------------------------------------------
// adc_bitslip_align
// Automatic word-alignment controller for NCH ADC serial channels. On start,
// each channel independently pulses its ISERDES2 BITSLIP until the parallel
// word equals the training PATTERN for MATCH_CNT consecutive words (locked),
// or gives up after MAX_SLIP slips (fail).
// Ports:
//   clk   : word clock (ISERDES2 CLKDIV), rising edge
//   rst_n : asynchronous active-low reset
//   bus   : adc_bitslip_align_if.slave (start/din in; dout/bs/locked/fail/
//           slips/busy out, all registered)
// ----------------------------------------------------------------------------
module adc_bitslip_align #(
  parameter int               NCH       = 4,
  parameter int               WIDTH     = 6,
  parameter logic [WIDTH-1:0] PATTERN   = 6'b111000,
  parameter int               SLIP_WAIT = 4,
  parameter int               MATCH_CNT = 8,
  parameter int               MAX_SLIP  = 11,
  parameter int               CNTW      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  adc_bitslip_align_if.slave  bus
);

  localparam int WCW = $clog2(SLIP_WAIT + 2);
  localparam int MCW = $clog2(MATCH_CNT + 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_CHECK  = 3'd2,
    S_SLIP   = 3'd3,
    S_LOCK   = 3'd4,
    S_FAILED = 3'd5
  } state_e;

  // Per-channel decoded outputs, registered together below.
  logic [NCH-1:0]      bs_d;
  logic [NCH-1:0]      locked_d;
  logic [NCH-1:0]      fail_d;
  logic [NCH-1:0]      busy_ch_d;
  logic [NCH*CNTW-1:0] slips_d;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    state_e           state_q, state_d;
    logic [WCW-1:0]   wcnt_q, wcnt_d;
    logic [MCW-1:0]   mcnt_q, mcnt_d;
    logic [CNTW-1:0]  scnt_q, scnt_d;
    logic [WIDTH-1:0] word_s;
    logic             bs_c, locked_c, fail_c, busy_c;

    assign word_s = bus.din[k*WIDTH +: WIDTH];

    // Channel state and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= S_IDLE;
        wcnt_q  <= {WCW{1'b0}};
        mcnt_q  <= {MCW{1'b0}};
        scnt_q  <= {CNTW{1'b0}};
      end else begin
        state_q <= state_d;
        wcnt_q  <= wcnt_d;
        mcnt_q  <= mcnt_d;
        scnt_q  <= scnt_d;
      end
    end

    // Channel next-state: start overrides everything and restarts the settle wait
    always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      mcnt_d  = mcnt_q;
      scnt_d  = scnt_q;
      if (bus.start) begin
        state_d = S_WAIT;
        wcnt_d  = WCW'(SLIP_WAIT);
        mcnt_d  = {MCW{1'b0}};
        scnt_d  = {CNTW{1'b0}};
      end else begin
        case (state_q)
          S_WAIT: begin
            // Leaves on the cycle the count reaches zero; DIN is not looked at.
            if (wcnt_q <= WCW'(1)) begin
              wcnt_d  = {WCW{1'b0}};
              state_d = S_CHECK;
            end else begin
              wcnt_d  = wcnt_q - WCW'(1);
            end
          end
          S_CHECK: begin
            if (word_s == PATTERN) begin
              mcnt_d = mcnt_q + MCW'(1);
              if (mcnt_q == MCW'(MATCH_CNT - 1)) begin
                state_d = S_LOCK;
              end else begin
                state_d = S_CHECK;
              end
            end else begin
              mcnt_d = {MCW{1'b0}};
              if (scnt_q < CNTW'(MAX_SLIP)) begin
                state_d = S_SLIP;
              end else begin
                state_d = S_FAILED;
              end
            end
          end
          S_SLIP: begin
            scnt_d  = scnt_q + CNTW'(1);
            wcnt_d  = WCW'(SLIP_WAIT);
            state_d = S_WAIT;
          end
          S_IDLE, S_LOCK, S_FAILED: begin
            state_d = state_q;
          end
          default: begin
            state_d = S_IDLE;
          end
        endcase
      end
    end

    // Channel output decode; a slip coinciding with a restart is not issued
    always_comb begin
      bs_c     = 1'b0;
      locked_c = 1'b0;
      fail_c   = 1'b0;
      busy_c   = 1'b0;
      case (state_q)
        S_SLIP: begin
          bs_c   = ~bus.start;
          busy_c = 1'b1;
        end
        S_WAIT, S_CHECK: begin
          busy_c = 1'b1;
        end
        S_LOCK: begin
          locked_c = 1'b1;
        end
        S_FAILED: begin
          fail_c = 1'b1;
        end
        S_IDLE: begin
          busy_c = 1'b0;
        end
        default: begin
          busy_c = 1'b0;
        end
      endcase
    end

    assign bs_d[k]                    = bs_c;
    assign locked_d[k]                = locked_c;
    assign fail_d[k]                  = fail_c;
    assign busy_ch_d[k]               = busy_c;
    assign slips_d[k*CNTW +: CNTW]    = scnt_q;
  end

  // Output registers toward the ISERDES2 and the channel processing logic
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.dout   <= {(NCH*WIDTH){1'b0}};
      bus.bs     <= {NCH{1'b0}};
      bus.locked <= {NCH{1'b0}};
      bus.fail   <= {NCH{1'b0}};
      bus.slips  <= {(NCH*CNTW){1'b0}};
      bus.busy   <= 1'b0;
    end else begin
      bus.dout   <= bus.din;
      bus.bs     <= bs_d;
      bus.locked <= locked_d;
      bus.fail   <= fail_d;
      bus.slips  <= slips_d;
      bus.busy   <= |busy_ch_d;
    end
  end

endmodule

// File: tb/tb_adc_bitslip_align.sv
// ----------------------------------------------------------------------------
// tb_adc_bitslip_align
// Self-checking bench: a table of hand-derived scenarios plus random scenarios,
// all checked cycle by cycle against a timeline model, and hand-written
// sequences for reset, restart during a slip, and async reset during the wait.
// Channel model: mode 0 = ISERDES that rotates the word one bit per BS pulse,
// mode 1 = dead channel (all zeros), mode 2 = already aligned and ignores BS.
// ----------------------------------------------------------------------------
module tb_adc_bitslip_align;
  localparam int NCH  = 2;
  localparam int W    = 6;
  localparam int CNTW = 4;
  localparam int SW   = 4;
  localparam int MC   = 8;
  localparam int MS   = 11;
  localparam int DW   = NCH * W;
  localparam logic [W-1:0] PAT = 6'b111000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  adc_bitslip_align_if #(.NCH(NCH), .WIDTH(W), .CNTW(CNTW)) bus ();

  adc_bitslip_align #(
    .NCH(NCH), .WIDTH(W), .PATTERN(PAT), .SLIP_WAIT(SW),
    .MATCH_CNT(MC), .MAX_SLIP(MS), .CNTW(CNTW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_edge = 0;
  int mode [NCH];
  int off [NCH];
  int corr_abs [NCH];
  int bs_seen [NCH];
  int last_bs [NCH];
  int obs_done [NCH];
  logic [DW-1:0] din_applied;

  // model predictions
  int m_done [NCH];
  bit m_lock [NCH];
  int m_ns [NCH];
  int m_bs [NCH][MS+1];
  int m_all_done;

  typedef struct {
    int md0, of0, cr0, md1, of1, cr1;
    int xs0, xs1;
    bit xl0, xl1;
    int xd0, xd1;
  } vec_t;
  vec_t tbl [4];

  task automatic check(input string name, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s ch%0d cyc=%0d got=%0d expected=%0d", name, k, cyc, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int r);
    logic [2*W-1:0] d;
    d = {v, v};
    return d[2*W-1-r -: W];
  endfunction

  // word the channel presents at edge t after s slips have been applied
  function automatic logic [W-1:0] word_of(input int k, input int s, input int t);
    logic [W-1:0] w;
    case (mode[k])
      0:       w = rotl(PAT, ((off[k] - s) % W + W) % W);
      1:       w = 6'b000000;
      default: w = PAT;
    endcase
    if (t == corr_abs[k]) w = ~w;
    return w;
  endfunction

  // Timeline model: first compare SW+1 edges after start, each slip costs SW+2 edges
  task automatic predict(input int s0);
    m_all_done = 0;
    for (int k = 0; k < NCH; k++) begin
      int t, m, s;
      bit fin;
      t = s0 + SW + 1; m = 0; s = 0; fin = 1'b0;
      for (int it = 0; it < 500 && !fin; it++) begin
        if (word_of(k, s, t) == PAT) begin
          m++;
          if (m == MC) begin m_lock[k] = 1'b1; m_done[k] = t + 1; fin = 1'b1; end
          else t++;
        end else begin
          m = 0;
          if (s < MS) begin m_bs[k][s] = t + 1; s++; t += SW + 2; end
          else begin m_lock[k] = 1'b0; m_done[k] = t + 1; fin = 1'b1; end
        end
      end
      m_ns[k] = s;
      if (m_done[k] > m_all_done) m_all_done = m_done[k];
    end
  endtask

  task automatic check_model();
    int e;
    e = cyc;
    check("dout", 0, int'(bus.dout), int'(din_applied));
    for (int k = 0; k < NCH; k++) begin
      bit bse;
      int nsb;
      bse = 1'b0; nsb = 0;
      for (int j = 0; j < m_ns[k]; j++) begin
        if (m_bs[k][j] == e) bse = 1'b1;
        if (m_bs[k][j] < e) nsb++;
      end
      check("bs", k, int'(bus.bs[k]), int'(bse));
      check("locked", k, int'(bus.locked[k]), int'(m_lock[k] && e >= m_done[k]));
      check("fail", k, int'(bus.fail[k]), int'(!m_lock[k] && e >= m_done[k]));
      check("slips", k, int'(bus.slips[k*CNTW +: CNTW]), nsb);
    end
    check("busy", 0, int'(bus.busy), int'(e < m_all_done));
  endtask

  task automatic drive_din();
    logic [DW-1:0] v;
    for (int k = 0; k < NCH; k++) v[k*W +: W] = word_of(k, bs_seen[k], cyc + 1);
    bus.din = v;
    din_applied = v;
  endtask

  task automatic tick(input bit chk);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    for (int k = 0; k < NCH; k++) begin
      if (bus.bs[k]) begin
        if (last_bs[k] >= 0) check("bs_spacing", k, int'(cyc - last_bs[k] >= SW + 2), 1);
        last_bs[k] = cyc;
        bs_seen[k]++;
      end
      if ((bus.locked[k] || bus.fail[k]) && obs_done[k] < 0 && cyc > start_edge)
        obs_done[k] = cyc;
    end
    if (chk) check_model();
    drive_din();
  endtask

  // Called at a negedge: configure channels, pulse start for the next edge
  task automatic start_run(input int md0, input int of0, input int cr0,
                           input int md1, input int of1, input int cr1);
    start_edge = cyc + 1;
    mode[0] = md0; off[0] = of0; corr_abs[0] = (cr0 > 0) ? start_edge + cr0 : -1;
    mode[1] = md1; off[1] = of1; corr_abs[1] = (cr1 > 0) ? start_edge + cr1 : -1;
    for (int k = 0; k < NCH; k++) begin
      bs_seen[k] = 0; last_bs[k] = -1; obs_done[k] = -1;
    end
    predict(start_edge);
    drive_din();
    bus.start = 1'b1;
    tick(1'b0);
    bus.start = 1'b0;
  endtask

  task automatic run_to_done(input int limit);
    for (int i = 0; i < limit && cyc < m_all_done + 2; i++) tick(1'b1);
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_dout"}, 0, int'(bus.dout), 0);
    check({tag, "_bs"}, 0, int'(bus.bs), 0);
    check({tag, "_locked"}, 0, int'(bus.locked), 0);
    check({tag, "_fail"}, 0, int'(bus.fail), 0);
    check({tag, "_slips"}, 0, int'(bus.slips), 0);
    check({tag, "_busy"}, 0, int'(bus.busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    //         md0 of0 cr0 md1 of1 cr1  xs0 xs1 xl0 xl1 xd0 xd1
    tbl[0] = '{2, 0, 0,  0, 3, 0,   0,  3,  1,  1,  13, 31};
    tbl[1] = '{1, 0, 0,  0, 0, 0,   11, 0,  0,  1,  72, 13};
    tbl[2] = '{2, 0, 9,  0, 5, 0,   1,  5,  1,  1,  23, 43};
    tbl[3] = '{0, 2, 0,  1, 0, 0,   2,  11, 1,  0,  25, 72};

    for (int k = 0; k < NCH; k++) begin
      mode[k] = 1; off[k] = 0; corr_abs[k] = -1; bs_seen[k] = 0;
      last_bs[k] = -1; obs_done[k] = -1;
    end

    // Reset held while inputs toggle: everything stays zero
    bus.start = 1'b1;
    bus.din = DW'($urandom);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      chk_zero("rst");
      bus.din = DW'($urandom);
    end
    bus.start = 1'b0;
    bus.din = {DW{1'b0}};
    din_applied = {DW{1'b0}};
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0);
      chk_zero("idle");
    end

    // Table-driven scenarios
    for (int r = 0; r < 4; r++) begin
      start_run(tbl[r].md0, tbl[r].of0, tbl[r].cr0, tbl[r].md1, tbl[r].of1, tbl[r].cr1);
      run_to_done(200);
      check("tbl_slips", 0, int'(bus.slips[0 +: CNTW]), tbl[r].xs0);
      check("tbl_slips", 1, int'(bus.slips[CNTW +: CNTW]), tbl[r].xs1);
      check("tbl_locked", 0, int'(bus.locked[0]), int'(tbl[r].xl0));
      check("tbl_locked", 1, int'(bus.locked[1]), int'(tbl[r].xl1));
      check("tbl_fail", 0, int'(bus.fail[0]), int'(!tbl[r].xl0));
      check("tbl_fail", 1, int'(bus.fail[1]), int'(!tbl[r].xl1));
      check("tbl_done", 0, obs_done[0] - start_edge, tbl[r].xd0);
      check("tbl_done", 1, obs_done[1] - start_edge, tbl[r].xd1);
    end

    // Random scenarios
    for (int r = 0; r < 6; r++) begin
      int md [NCH], of [NCH], cr [NCH];
      for (int k = 0; k < NCH; k++) begin
        md[k] = $urandom_range(0, 2);
        of[k] = $urandom_range(0, W - 1);
        cr[k] = ($urandom_range(0, 1) == 1) ? $urandom_range(5, 40) : 0;
      end
      start_run(md[0], of[0], cr[0], md[1], of[1], cr[1]);
      run_to_done(200);
    end

    // Restart while ch0 is in SLIP and ch1 is locked
    start_run(1, 0, 0, 2, 0, 0);
    for (int i = 0; i < 17; i++) tick(1'b1);
    bus.start = 1'b1;
    tick(1'b0);
    bus.start = 1'b0;
    check("rs_bs_suppressed", 0, int'(bus.bs[0]), 0);
    check("rs_prev_locked", 1, int'(bus.locked[1]), 1);
    check("rs_prev_slips", 0, int'(bus.slips[0 +: CNTW]), 2);
    tick(1'b0);
    check("rs_locked", 0, int'(bus.locked), 0);
    check("rs_slips", 0, int'(bus.slips), 0);
    check("rs_bs", 0, int'(bus.bs), 0);
    check("rs_fail", 0, int'(bus.fail), 0);
    check("rs_busy", 0, int'(bus.busy), 1);

    // Async reset in the middle of the settle wait
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async");
    @(posedge clk); cyc++;
    @(negedge clk);
    chk_zero("async_hold");
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
